// File: rtl/apb_ucpd_tick_gen.sv
// UCPD timebase: prescaled ucpd_tick, half-bit and bit strobes with phase, and
// NTMR independent gap timers counting a selectable tick, all in the ic_clk domain.
module apb_ucpd_tick_gen #(
    parameter int PSC_W  = 3,
    parameter int HDIV_W = 6,
    parameter int TMR_W  = 5,
    parameter int NTMR   = 2
) (
    input  logic                  ic_clk,
    input  logic                  ic_rst,
    input  logic                  gen_en,
    input  logic [PSC_W-1:0]      psc_usbpdclk,
    input  logic [HDIV_W-1:0]     hbitclkdiv,
    input  logic [NTMR-1:0]       tmr_start,
    input  logic [NTMR-1:0]       tmr_stop,
    input  logic [NTMR-1:0]       tmr_src,
    input  logic [NTMR-1:0]       tmr_periodic,
    input  logic [NTMR*TMR_W-1:0] tmr_thresh,
    output logic                  ucpd_tick,
    output logic                  hbit_tick,
    output logic                  bit_tick,
    output logic                  bit_phase,
    output logic [NTMR-1:0]       tmr_busy,
    output logic [NTMR-1:0]       tmr_done
);

    localparam int PCNT_W = (2 ** PSC_W) - 1;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} tmr_state_e;

    logic                 en_q, en_d;
    logic [PSC_W-1:0]     psc_q, psc_d;
    logic [HDIV_W-1:0]    hdiv_q, hdiv_d;
    logic [PCNT_W-1:0]    pscCnt_q, pscCnt_d;
    logic [HDIV_W-1:0]    hbitCnt_q, hbitCnt_d;
    logic                 bitPhase_q, bitPhase_d;
    logic                 ucpd_q, ucpd_d;
    logic                 hbit_q, hbit_d;
    logic                 bit_q, bit_d;
    logic [PCNT_W-1:0]    pscTerm;
    logic                 cfgChanged;

    tmr_state_e           state_q [NTMR];
    tmr_state_e           state_d [NTMR];
    logic [TMR_W-1:0]     tcnt_q [NTMR];
    logic [TMR_W-1:0]     tcnt_d [NTMR];
    logic [NTMR-1:0]      done_q, done_d;

    // Terminal count 2^code-1 as a mask, so code 0 terminates every cycle.
    assign pscTerm    = ~({PCNT_W{1'b1}} << psc_usbpdclk);
    assign cfgChanged = (psc_usbpdclk != psc_q) || (hbitclkdiv != hdiv_q);

    // en_q delays counting by one cycle so the first tick lands 2^code cycles
    // after enable; a config change restarts the chain the same way.
    always_comb begin
        en_d       = gen_en;
        psc_d      = psc_q;
        hdiv_d     = hdiv_q;
        pscCnt_d   = pscCnt_q;
        hbitCnt_d  = hbitCnt_q;
        bitPhase_d = bitPhase_q;
        ucpd_d     = 1'b0;
        hbit_d     = 1'b0;
        bit_d      = 1'b0;
        if (!gen_en) begin
            pscCnt_d   = '0;
            hbitCnt_d  = '0;
            bitPhase_d = 1'b0;
        end else begin
            psc_d  = psc_usbpdclk;
            hdiv_d = hbitclkdiv;
            if (!en_q || cfgChanged) begin
                pscCnt_d   = '0;
                hbitCnt_d  = '0;
                bitPhase_d = 1'b0;
            end else if (pscCnt_q == pscTerm) begin
                pscCnt_d = '0;
                ucpd_d   = 1'b1;
                if (hbitCnt_q == hbitclkdiv) begin
                    hbitCnt_d  = '0;
                    hbit_d     = 1'b1;
                    bitPhase_d = ~bitPhase_q;
                    bit_d      = bitPhase_q;
                end else begin
                    hbitCnt_d = hbitCnt_q + 1'b1;
                end
            end else begin
                pscCnt_d = pscCnt_q + 1'b1;
            end
        end
    end

    // Timers count the registered tick outputs; stop beats start beats tick.
    always_comb begin
        done_d = '0;
        for (int i = 0; i < NTMR; i++) begin
            state_d[i] = state_q[i];
            tcnt_d[i]  = tcnt_q[i];
            if (!gen_en || tmr_stop[i]) begin
                state_d[i] = IDLE;
                tcnt_d[i]  = '0;
            end else if (tmr_start[i]) begin
                state_d[i] = RUN;
                tcnt_d[i]  = '0;
            end else if (state_q[i] == RUN && (tmr_src[i] ? hbit_q : ucpd_q)) begin
                if (({1'b0, tcnt_q[i]} + 1'b1) >= {1'b0, tmr_thresh[i*TMR_W +: TMR_W]}) begin
                    done_d[i]  = 1'b1;
                    tcnt_d[i]  = '0;
                    state_d[i] = tmr_periodic[i] ? RUN : IDLE;
                end else begin
                    tcnt_d[i] = tcnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge ic_clk or posedge ic_rst) begin
        if (ic_rst) begin
            en_q       <= 1'b0;
            psc_q      <= '0;
            hdiv_q     <= '0;
            pscCnt_q   <= '0;
            hbitCnt_q  <= '0;
            bitPhase_q <= 1'b0;
            ucpd_q     <= 1'b0;
            hbit_q     <= 1'b0;
            bit_q      <= 1'b0;
            done_q     <= '0;
            for (int i = 0; i < NTMR; i++) begin
                state_q[i] <= IDLE;
                tcnt_q[i]  <= '0;
            end
        end else begin
            en_q       <= en_d;
            psc_q      <= psc_d;
            hdiv_q     <= hdiv_d;
            pscCnt_q   <= pscCnt_d;
            hbitCnt_q  <= hbitCnt_d;
            bitPhase_q <= bitPhase_d;
            ucpd_q     <= ucpd_d;
            hbit_q     <= hbit_d;
            bit_q      <= bit_d;
            done_q     <= done_d;
            for (int i = 0; i < NTMR; i++) begin
                state_q[i] <= state_d[i];
                tcnt_q[i]  <= tcnt_d[i];
            end
        end
    end

    assign ucpd_tick = ucpd_q;
    assign hbit_tick = hbit_q;
    assign bit_tick  = bit_q;
    assign bit_phase = bitPhase_q;
    assign tmr_done  = done_q;

    always_comb begin
        for (int i = 0; i < NTMR; i++) begin
            tmr_busy[i] = (state_q[i] == RUN);
        end
    end

endmodule

// File: doc/apb_ucpd_tick_gen.md
APB_UCPD_TICK_GEN -- requirements
Module: apb_ucpd_tick_gen

Interface
REQ-001 Parameters SHALL be:
  PSC_W   3  prescaler code width; divide ratio 2^code, code 0..2^PSC_W-1
  HDIV_W  6  half-bit divider width
  TMR_W   5  gap-timer threshold width
  NTMR    2  number of independent gap timers (ch0 = interframe gap, ch1 = transition window)
REQ-002 Ports SHALL be:
  ic_clk        in   1            processor clock; the only clock, all logic on its rising edge
  ic_rst        in   1            asynchronous reset, active-high
  gen_en        in   1            tick generation enable
  psc_usbpdclk  in   PSC_W        prescaler code
  hbitclkdiv    in   HDIV_W       half-bit divisor minus 1
  tmr_start     in   NTMR         per-channel start/restart strobe
  tmr_stop      in   NTMR         per-channel abort strobe
  tmr_src       in   NTMR         per-channel tick source: 0 = ucpd_tick, 1 = hbit_tick
  tmr_periodic  in   NTMR         per-channel mode: 0 = one-shot, 1 = auto-reload
  tmr_thresh    in   NTMR*TMR_W   per-channel threshold, channel i at [i*TMR_W +: TMR_W]
  ucpd_tick     out  1            one-cycle strobe per UCPD_CLK period
  hbit_tick     out  1            one-cycle strobe per half-bit period
  bit_tick      out  1            one-cycle strobe per bit period
  bit_phase     out  1            half-bit phase within current bit
  tmr_busy      out  NTMR         channel running
  tmr_done      out  NTMR         one-cycle expiry strobe
REQ-003 All outputs SHALL be driven directly from flops; the block SHALL NOT generate derived clocks.

Function
REQ-004 Prescaler counter width SHALL be 2^PSC_W-1 bits; ucpd_tick SHALL pulse once every 2^psc_usbpdclk ic_clk cycles; code 0 gives ucpd_tick high every cycle.
REQ-005 The first ucpd_tick SHALL appear 2^code cycles after the edge on which gen_en is first sampled high.
REQ-006 The half-bit counter SHALL count ucpd_ticks; hbit_tick SHALL coincide with every (hbitclkdiv+1)-th ucpd_tick; hbitclkdiv=0 gives hbit_tick identical to ucpd_tick.
REQ-007 bit_phase SHALL toggle on every hbit_tick; bit_tick SHALL pulse with each hbit_tick on which bit_phase was 1 before toggling, i.e. the 2nd, 4th, ... hbit_tick.
REQ-008 A change of psc_usbpdclk or hbitclkdiv, registered and compared each cycle while gen_en is high, SHALL clear the prescaler counter, half-bit counter and bit_phase; no tick SHALL be issued in that cycle.
REQ-009 gen_en low SHALL hold all counters at 0, bit_phase at 0, all ticks at 0, and every timer channel in IDLE with tmr_done at 0.
REQ-010 Each timer channel SHALL be an FSM with states IDLE and RUN and a TMR_W-bit counter; tmr_busy = (state == RUN).
REQ-011 IDLE -> RUN on tmr_start with counter cleared; in RUN the counter SHALL increment on each tick selected by tmr_src.
REQ-012 When a selected tick arrives with counter == tmr_thresh-1, tmr_done SHALL pulse next cycle; one-shot -> IDLE; periodic -> counter 0, stay RUN.
REQ-013 tmr_thresh = 0 SHALL expire on the first selected tick after start.
REQ-014 Priority per channel SHALL be tmr_stop > tmr_start > tick; stop -> IDLE with no done; start in RUN restarts at 0 with no done; a tick coincident with start SHALL NOT be counted.
REQ-015 tmr_src, tmr_periodic and tmr_thresh SHALL be sampled live each cycle; lowering tmr_thresh below the current count SHALL expire on the next selected tick.
REQ-016 Channels SHALL be fully independent; simultaneous done on multiple channels SHALL all be reported.

Reset
REQ-017 ic_rst high SHALL asynchronously force all counters, bit_phase, ucpd_tick, hbit_tick, bit_tick, tmr_busy and tmr_done to 0, all FSMs to IDLE, and clear the config-change registers to 0.
REQ-018 Reset SHALL abort any running timer without a done pulse; after deassertion operation SHALL restart per REQ-005.

Verification
REQ-019 psc=3, hbitclkdiv=4, gen_en rise -> ucpd_tick every 8 cycles, first after 8; hbit_tick every 40 cycles; bit_tick every 80 cycles.
REQ-020 psc=0, hbitclkdiv=0 -> ucpd_tick and hbit_tick constant 1, bit_phase toggles every cycle, bit_tick every 2nd cycle.
REQ-021 ch0 src=0, thresh=5, one-shot, psc=1, start -> tmr_done one cycle after the 5th ucpd_tick, i.e. about 10 cycles later; busy falls with the done pulse.
REQ-022 ch1 src=1, periodic, thresh=3, hbitclkdiv=1 -> done every 6 ucpd_ticks; stop and start asserted together -> IDLE, no further done.
REQ-023 Change hbitclkdiv mid-run -> counters and bit_phase clear, the next hbit_tick follows the new period exactly, and the timer continues counting.
REQ-024 ic_rst pulse while a channel is RUN -> all outputs 0 immediately, no done pulse; after release a restart with thresh=0 expires on the first tick.
